// File: rtl/ex_tracker_pkg.sv
// Shared trace datatypes for the ryuki trace trackers: element layout, tracker
// state encoding, default queue depth and a wrap-safe time comparison.
package ryuki_datatypes;

  localparam int TRACE_ADDR_WIDTH          = 32;
  localparam int TRACE_DATA_WIDTH          = 32;
  localparam int TRACE_QUEUE_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] time_start;
    logic [31:0] time_end;
  } trace_time_t;

  typedef struct packed {
    logic                        pass_through;
    logic [TRACE_ADDR_WIDTH-1:0] addr;
    logic [TRACE_DATA_WIDTH-1:0] instr;
    trace_time_t                 id_data;
    trace_time_t                 ex_data;
    trace_time_t                 wb_data;
  } trace_output;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_WAIT = 2'd1,
    EX_MEM  = 2'd2,
    EX_EMIT = 2'd3
  } ex_state_t;

  // True once now has reached start, treating the counter as a wrapping timeline.
  function automatic logic time_reached(input logic [31:0] now, input logic [31:0] start);
    logic [31:0] diff;
    diff = now - start;
    return ~diff[31];
  endfunction

endpackage

// File: rtl/ex_tracker_fifo.sv
// trace_fifo: small first-word-fall-through queue of trace elements with
// extra-MSB pointers; a pop at the same edge frees room for a push when full.
module trace_fifo
  import ryuki_datatypes::*;
#(
  parameter int DEPTH = TRACE_QUEUE_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  trace_output din,
  output trace_output dout,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH) + 1;

  trace_output   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          push_en, pop_en;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  assign wr_ptr_d = push_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop_en  ? rd_ptr_q + PW'(1) : rd_ptr_q;
  assign dout     = mem_q[rd_ptr_q[PW-2:0]];

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[PW-2:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/ex_tracker.sv
// ex_tracker: time-stamps the execute phase of decoded trace elements.
// Define EX_TRACKER_MEM_TIMING_EN to extend time_end to the data-memory response.
module ex_tracker
  import ryuki_datatypes::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int QUEUE_DEPTH = TRACE_QUEUE_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] counter,
  input  logic        id_data_ready,
  input  trace_output id_data_i,
  input  logic        ex_ready,
  input  logic        data_req,
  input  logic        data_gnt,
  input  logic        data_rvalid,
  output trace_output ex_data_o,
  output logic        ex_data_ready,
  output logic        overflow
);

  if (ADDR_WIDTH != TRACE_ADDR_WIDTH || DATA_WIDTH != TRACE_DATA_WIDTH ||
      QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_param_check
    $error("ex_tracker: widths must match ryuki_datatypes and QUEUE_DEPTH must be a power of two >= 2");
  end

  ex_state_t   state_q, state_d;
  trace_output work_q, work_d;
  trace_output ex_data_q, ex_data_d;
  logic        ex_valid_q, ex_valid_d;
  logic        overflow_q, overflow_d;
  logic        mem_seen_q, mem_seen_d;
  logic        fifo_pop, fifo_full, fifo_empty;
  trace_output fifo_dout;
  logic        ready_ok;

  trace_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (id_data_ready),
    .pop   (fifo_pop),
    .din   (id_data_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifndef EX_TRACKER_MEM_TIMING_EN
  logic unused_mem;
  assign unused_mem = data_req ^ data_gnt ^ data_rvalid;
`endif

  assign ready_ok   = ex_ready && time_reached(counter, work_q.ex_data.time_start);
  assign overflow_d = overflow_q | (id_data_ready & fifo_full & ~fifo_pop);

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    mem_seen_d = mem_seen_q;
    ex_data_d  = ex_data_q;
    ex_valid_d = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      EX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          work_d   = fifo_dout;
          if (fifo_dout.pass_through) begin
            work_d.ex_data = '0;
            work_d.wb_data = '0;
            state_d        = EX_EMIT;
          end else begin
            work_d.ex_data.time_start = fifo_dout.id_data.time_end + 32'd1;
            mem_seen_d                = 1'b0;
            state_d                   = EX_WAIT;
          end
        end
      end
      EX_WAIT: begin
`ifdef EX_TRACKER_MEM_TIMING_EN
        mem_seen_d = mem_seen_q | (data_req & data_gnt);
`endif
        if (ready_ok) begin
          work_d.ex_data.time_end = counter;
          state_d                 = EX_EMIT;
`ifdef EX_TRACKER_MEM_TIMING_EN
          // A response landing with ex_ready already closes the transaction.
          if (mem_seen_d && !data_rvalid) state_d = EX_MEM;
`endif
        end
      end
      EX_MEM: begin
`ifdef EX_TRACKER_MEM_TIMING_EN
        if (data_rvalid) begin
          work_d.ex_data.time_end = counter;
          state_d                 = EX_EMIT;
        end
`else
        state_d = EX_IDLE;
`endif
      end
      EX_EMIT: begin
        ex_data_d  = work_q;
        ex_valid_d = 1'b1;
        state_d    = EX_IDLE;
      end
      default: state_d = EX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EX_IDLE;
      work_q     <= '0;
      mem_seen_q <= 1'b0;
      ex_data_q  <= '0;
      ex_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      mem_seen_q <= mem_seen_d;
      ex_data_q  <= ex_data_d;
      ex_valid_q <= ex_valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign ex_data_o     = ex_data_q;
  assign ex_data_ready = ex_valid_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_ex_tracker.sv
// Scoreboard bench for ex_tracker: directed elements with hand-computed time
// stamps and pulse cycles; a forked monitor checks every ex_data_ready pulse.
module tb_ex_tracker;
  import ryuki_datatypes::*;

  localparam int TW = $bits(trace_output);

  typedef struct {
    trace_output data;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] counter;
  logic        id_data_ready;
  trace_output id_data_i;
  logic        ex_ready, data_req, data_gnt, data_rvalid;
  trace_output ex_data_o;
  logic        ex_data_ready, overflow;

  exp_t        exp_q[$];
  trace_output last_exp;
  int          n_checks = 0;
  int          n_fails  = 0;

  always #5 clk = ~clk;

  ex_tracker dut (
    .clk           (clk),
    .rst           (rst),
    .counter       (counter),
    .id_data_ready (id_data_ready),
    .id_data_i     (id_data_i),
    .ex_ready      (ex_ready),
    .data_req      (data_req),
    .data_gnt      (data_gnt),
    .data_rvalid   (data_rvalid),
    .ex_data_o     (ex_data_o),
    .ex_data_ready (ex_data_ready),
    .overflow      (overflow)
  );

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Inputs change after the falling edge; the next rising edge sees counter.
  task automatic cyc();
    @(negedge clk);
    counter = counter + 32'd1;
  endtask

  task automatic at(input logic [31:0] n);
    int k = 0;
    while (counter != n && k < 1000) begin
      cyc();
      k++;
    end
    if (counter != n) begin
      n_checks++;
      n_fails++;
      $display("FAIL at_bound: counter %0d, required %0d", counter, n);
    end
  endtask

  task automatic push(input trace_output e);
    id_data_ready = 1'b1;
    id_data_i     = e;
    cyc();
    id_data_ready = 1'b0;
  endtask

  task automatic expect_pulse(input trace_output e, input logic [31:0] c);
    exp_t x;
    x.data = e;
    x.cyc  = c;
    exp_q.push_back(x);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      cyc();
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) cyc();
  endtask

  function automatic trace_output mk(input logic pt, input logic [31:0] addr, input logic [31:0] id_end);
    trace_output e;
    e.pass_through       = pt;
    e.addr               = addr;
    e.instr              = ~addr;
    e.id_data.time_start = id_end - 32'd10;
    e.id_data.time_end   = id_end;
    e.ex_data.time_start = 32'hDEAD_BEEF;
    e.ex_data.time_end   = 32'hCAFE_F00D;
    e.wb_data.time_start = 32'h1111_2222;
    e.wb_data.time_end   = 32'h3333_4444;
    return e;
  endfunction

  function automatic trace_output timed(input trace_output e, input logic [31:0] s, input logic [31:0] t);
    trace_output r;
    r                    = e;
    r.ex_data.time_start = s;
    r.ex_data.time_end   = t;
    return r;
  endfunction

  function automatic trace_output passed(input trace_output e);
    trace_output r;
    r         = e;
    r.ex_data = '0;
    r.wb_data = '0;
    return r;
  endfunction

  task automatic monitor();
    exp_t x;
    logic prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ex_data_ready) begin
        check("pulse_gap", TW'(prev), TW'(1'b0));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_pulse: got pulse at counter %0d addr %h, required none", counter, ex_data_o.addr);
        end else begin
          x        = exp_q.pop_front();
          last_exp = x.data;
          $display("pulse counter=%0d addr=%h ex=%0d..%0d", counter, ex_data_o.addr,
                   ex_data_o.ex_data.time_start, ex_data_o.ex_data.time_end);
          check("ex_data", TW'(ex_data_o), TW'(x.data));
          check("pulse_cycle", TW'(counter), TW'(x.cyc));
        end
      end
      prev = ex_data_ready;
    end
  endtask

  initial begin
    trace_output e;
    rst = 1'b0; counter = '0; id_data_ready = 1'b0; id_data_i = '0;
    ex_ready = 1'b0; data_req = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b0;
    last_exp = '0;
    fork
      monitor();
    join_none

    // Reset and idle
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    check("rst_ready", TW'(ex_data_ready), TW'(1'b0));
    check("rst_overflow", TW'(overflow), TW'(1'b0));
    check("rst_data", TW'(ex_data_o), TW'(0));
    repeat (20) cyc();

    // Basic timing
    counter = 32'd100;
    at(32'd101);
    e = mk(1'b0, 32'h1000, 32'd100);
    expect_pulse(timed(e, 32'd101, 32'd104), 32'd105);
    push(e);
    at(32'd104);
    ex_ready = 1'b1;
    cyc();
    ex_ready = 1'b0;
    drain();
    repeat (3) cyc();
    check("hold_data", TW'(ex_data_o), TW'(last_exp));

    // Pass-through with ex_ready asserted
    counter = 32'd149;
    at(32'd150);
    ex_ready = 1'b1;
    e = mk(1'b1, 32'h2000, 32'd140);
    expect_pulse(passed(e), 32'd152);
    push(e);
    repeat (3) cyc();
    ex_ready = 1'b0;
    drain();

    // Memory transaction timing
    counter = 32'd200;
    at(32'd201);
    e = mk(1'b0, 32'h3000, 32'd200);
`ifdef EX_TRACKER_MEM_TIMING_EN
    expect_pulse(timed(e, 32'd201, 32'd209), 32'd210);
`else
    expect_pulse(timed(e, 32'd201, 32'd206), 32'd207);
`endif
    push(e);
    at(32'd205);
    data_req = 1'b1; data_gnt = 1'b1;
    cyc();
    data_req = 1'b0; data_gnt = 1'b0;
    ex_ready = 1'b1;
    cyc();
    ex_ready = 1'b0;
    at(32'd209);
    data_rvalid = 1'b1;
    cyc();
    data_rvalid = 1'b0;
    drain();

    // ex_ready held before time_start is ignored
    counter = 32'd299;
    at(32'd300);
    e = mk(1'b0, 32'h4000, 32'd310);
    expect_pulse(timed(e, 32'd311, 32'd311), 32'd312);
    push(e);
    at(32'd302);
    ex_ready = 1'b1;
    at(32'd313);
    ex_ready = 1'b0;
    drain();

    // Counter wrap across the execute window
    counter = 32'hFFFF_FFF9;
    at(32'hFFFF_FFFA);
    e = mk(1'b0, 32'h5000, 32'hFFFF_FFFF);
    expect_pulse(timed(e, 32'd0, 32'd0), 32'd1);
    push(e);
    at(32'hFFFF_FFFC);
    ex_ready = 1'b1;
    at(32'd2);
    ex_ready = 1'b0;
    drain();

    // Overflow: one element in the working register plus four queued, sixth dropped
    counter = 32'd400;
    for (int i = 1; i <= 6; i++) begin
      e = mk(1'b0, 32'h6000 + 32'(i), 32'd0);
      if (i <= 5) expect_pulse(timed(e, 32'd1, 32'(407 + 3 * i)), 32'(408 + 3 * i));
      if (i == 6) check("overflow_at_full", TW'(overflow), TW'(1'b0));
      push(e);
    end
    check("overflow_set", TW'(overflow), TW'(1'b1));
    at(32'd410);
    ex_ready = 1'b1;
    at(32'd412);
    e = mk(1'b0, 32'h6007, 32'd0);
    expect_pulse(timed(e, 32'd1, 32'd425), 32'd426);
    push(e);
    at(32'd427);
    ex_ready = 1'b0;
    drain();
    check("overflow_sticky", TW'(overflow), TW'(1'b1));

    // Asynchronous reset while elements are waiting
    counter = 32'd500;
    for (int i = 1; i <= 3; i++) push(mk(1'b0, 32'h7000 + 32'(i), 32'd0));
    at(32'd506);
    #2 rst = 1'b0;
    #1;
    check("async_ready", TW'(ex_data_ready), TW'(1'b0));
    check("async_data", TW'(ex_data_o), TW'(0));
    check("async_overflow", TW'(overflow), TW'(1'b0));
    repeat (3) cyc();
    rst = 1'b1;
    ex_ready = 1'b1;
    repeat (10) cyc();
    check("post_rst_overflow", TW'(overflow), TW'(1'b0));
    counter = 32'd600;
    at(32'd601);
    e = mk(1'b0, 32'h8000, 32'd600);
    expect_pulse(timed(e, 32'd601, 32'd603), 32'd604);
    push(e);
    drain();
    ex_ready = 1'b0;
    repeat (5) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
